// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with exception/eret redirect, epc
// capture, misaligned-redirect flag and an optional return-address stack.
// Optional feature macro: PC_RAS_EN (return-address stack for jr returns).
module pc_unit #(
  parameter int unsigned     SIZE      = 64,
  parameter logic [SIZE-1:0] RESET_VEC = '0,
  parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(64'h80),
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCen,
  input  logic            exc,
  input  logic            eret,
  input  logic            branch_taken,
  input  logic [SIZE-1:0] branch_target,
  input  logic            jump,
  input  logic [SIZE-1:0] jump_target,
  input  logic            call,
  input  logic            ret,
  output logic [SIZE-1:0] index_out,
  output logic [SIZE-1:0] index_plus,
  output logic [SIZE-1:0] epc,
  output logic            addr_err,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [SIZE-1:0] ALIGN_MASK = ~SIZE'(3);

  // RAS_DEPTH must be a power of two and at least 2
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of 2 and >= 2");
  end

  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] epc_q, epc_d;
  logic            addr_err_q, addr_err_d;
  logic [SIZE-1:0] redir_tgt;

  assign index_out  = pc_q;
  assign index_plus = pc_q + SIZE'(INC);
  assign epc        = epc_q;
  assign addr_err   = addr_err_q;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SIZE-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] ras_waddr;
  logic             ras_we;
  logic             ras_nonempty;
  logic             ras_full_now;
  logic             ras_empty_q, ras_full_q;

  assign top_idx      = ptr_q - PTR_W'(1);
  assign ras_nonempty = (cnt_q != '0);
  assign ras_full_now = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_empty    = ras_empty_q;
  assign ras_full     = ras_full_q;
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = &{1'b0, call, ret};
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  // Next-PC selection: exc > eret > jump > branch > sequential
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    addr_err_d = 1'b0;
    redir_tgt  = '0;
`ifdef PC_RAS_EN
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
`endif
    if (exc) begin
      pc_d  = EXC_VEC;
      epc_d = pc_q;
    end else if (eret) begin
      pc_d = epc_q;
    end else if (PCen) begin
      if (jump) begin
        redir_tgt = jump_target;
`ifdef PC_RAS_EN
        if (ret && ras_nonempty) redir_tgt = ras_mem[top_idx];
        if (call && ret && ras_nonempty) begin
          // pop then push collapses to replacing the top entry in place
          ras_we    = 1'b1;
          ras_waddr = top_idx;
        end else if (call) begin
          ras_we    = 1'b1;
          ras_waddr = ptr_q;
          ptr_d     = ptr_q + PTR_W'(1);
          if (!ras_full_now) cnt_d = cnt_q + CNT_W'(1);
        end else if (ret && ras_nonempty) begin
          ptr_d = top_idx;
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
        pc_d       = redir_tgt & ALIGN_MASK;
        addr_err_d = |redir_tgt[1:0];
      end else if (branch_taken) begin
        redir_tgt  = branch_target;
        pc_d       = redir_tgt & ALIGN_MASK;
        addr_err_d = |redir_tgt[1:0];
      end else begin
        pc_d = index_plus;
      end
    end
  end

  // PC, epc and error-flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef PC_RAS_EN
  // RAS pointer, occupancy and status flags; entries above count are never read
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ras_empty_q <= (cnt_d == '0);
      ras_full_q  <= (cnt_d == CNT_W'(RAS_DEPTH));
    end
  end

  // RAS storage, no reset needed since the count gates every read
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= index_plus;
  end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (default and PC_RAS_EN builds).
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCen;
  logic        exc;
  logic        eret;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        jump;
  logic [63:0] jump_target;
  logic        call;
  logic        ret;
  logic [63:0] index_out;
  logic [63:0] index_plus;
  logic [63:0] epc;
  logic        addr_err;
  logic        ras_empty;
  logic        ras_full;

  int tests_run    = 0;
  int tests_failed = 0;

  pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .PCen         (PCen),
    .exc          (exc),
    .eret         (eret),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .call         (call),
    .ret          (ret),
    .index_out    (index_out),
    .index_plus   (index_plus),
    .epc          (epc),
    .addr_err     (addr_err),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    exc = 1'b0; eret = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    call = 1'b0; ret = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; PCen = 1'b0; clear_ctl();
    branch_target = '0; jump_target = '0;
    tick();
    tests_run++; if (index_out !== 64'h0) begin tests_failed++; $display("FAIL reset_c1 index_out=%h exp=%h", index_out, 64'h0); end
    tick();
    tests_run++; if (index_out !== 64'h0) begin tests_failed++; $display("FAIL reset_c2 index_out=%h exp=%h", index_out, 64'h0); end
    tests_run++; if (epc !== 64'h0) begin tests_failed++; $display("FAIL reset_epc epc=%h exp=%h", epc, 64'h0); end
    tests_run++; if (addr_err !== 1'b0 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin tests_failed++; $display("FAIL reset_flags err/empty/full=%b%b%b exp=010", addr_err, ras_empty, ras_full); end
    rst = 1'b0; PCen = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'h4) begin tests_failed++; $display("FAIL seq_1 index_out=%h exp=%h", index_out, 64'h4); end
    tick();
    tests_run++; if (index_out !== 64'h8) begin tests_failed++; $display("FAIL seq_2 index_out=%h exp=%h", index_out, 64'h8); end
    tick();
    tests_run++; if (index_out !== 64'hC) begin tests_failed++; $display("FAIL seq_3 index_out=%h exp=%h", index_out, 64'hC); end
    tests_run++; if (index_plus !== 64'h10) begin tests_failed++; $display("FAIL seq_plus index_plus=%h exp=%h", index_plus, 64'h10); end
  endtask

  task automatic test_branch_stall();
    tick();
    tests_run++; if (index_out !== 64'h10) begin tests_failed++; $display("FAIL br_setup index_out=%h exp=%h", index_out, 64'h10); end
    PCen = 1'b0; branch_taken = 1'b1; branch_target = 64'h40;
    tick();
    tests_run++; if (index_out !== 64'h10) begin tests_failed++; $display("FAIL br_stall index_out=%h exp=%h", index_out, 64'h10); end
    PCen = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'h40 || addr_err !== 1'b0) begin tests_failed++; $display("FAIL br_taken index_out=%h err=%b exp=%h err=0", index_out, addr_err, 64'h40); end
    branch_target = 64'h42;
    tick();
    tests_run++; if (index_out !== 64'h40 || addr_err !== 1'b1) begin tests_failed++; $display("FAIL br_misalign index_out=%h err=%b exp=%h err=1", index_out, addr_err, 64'h40); end
    branch_taken = 1'b0;
    tick();
    tests_run++; if (index_out !== 64'h44 || addr_err !== 1'b0) begin tests_failed++; $display("FAIL br_err_pulse index_out=%h err=%b exp=%h err=0", index_out, addr_err, 64'h44); end
  endtask

  task automatic test_exception();
    jump = 1'b1; jump_target = 64'h20;
    tick();
    tests_run++; if (index_out !== 64'h20) begin tests_failed++; $display("FAIL exc_setup index_out=%h exp=%h", index_out, 64'h20); end
    exc = 1'b1; PCen = 1'b0; jump_target = 64'h100;
    tick();
    tests_run++; if (index_out !== 64'h80 || epc !== 64'h20) begin tests_failed++; $display("FAIL exc_take index_out=%h epc=%h exp=%h/%h", index_out, epc, 64'h80, 64'h20); end
    exc = 1'b0; jump = 1'b0; eret = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'h20) begin tests_failed++; $display("FAIL eret index_out=%h exp=%h", index_out, 64'h20); end
    exc = 1'b1; eret = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'h80 || epc !== 64'h20) begin tests_failed++; $display("FAIL exc_eret index_out=%h epc=%h exp=%h/%h", index_out, epc, 64'h80, 64'h20); end
    clear_ctl();
    tick();
    tests_run++; if (index_out !== 64'h80) begin tests_failed++; $display("FAIL exc_stall index_out=%h exp=%h", index_out, 64'h80); end
    PCen = 1'b1;
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    tests_run++; if (index_plus !== 64'h0) begin tests_failed++; $display("FAIL wrap_plus index_plus=%h exp=%h", index_plus, 64'h0); end
    jump = 1'b0;
    tick();
    tests_run++; if (index_out !== 64'h0 || index_plus !== 64'h4) begin tests_failed++; $display("FAIL wrap index_out=%h plus=%h exp=0/4", index_out, index_plus); end
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_target = 64'h200; branch_taken = 1'b1; branch_target = 64'h300;
    tick();
    tests_run++; if (index_out !== 64'h200) begin tests_failed++; $display("FAIL jump_prio index_out=%h exp=%h", index_out, 64'h200); end
    branch_taken = 1'b0; jump_target = 64'h203;
    tick();
    tests_run++; if (index_out !== 64'h200 || addr_err !== 1'b1) begin tests_failed++; $display("FAIL jump_misalign index_out=%h err=%b exp=%h err=1", index_out, addr_err, 64'h200); end
    clear_ctl();
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    jump = 1'b1; jump_target = 64'h100;
    tick();
    call = 1'b1; jump_target = 64'h400;
    tick();
    tests_run++; if (index_out !== 64'h400 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL ras_call index_out=%h empty=%b exp=%h empty=0", index_out, ras_empty, 64'h400); end
    call = 1'b0; ret = 1'b1; jump_target = 64'hDEAD0;
    tick();
    tests_run++; if (index_out !== 64'h104 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ras_ret index_out=%h empty=%b exp=%h empty=1", index_out, ras_empty, 64'h104); end
    tick();
    tests_run++; if (index_out !== 64'hDEAD0) begin tests_failed++; $display("FAIL ras_ret_empty index_out=%h exp=%h", index_out, 64'hDEAD0); end
    clear_ctl();
  endtask

  task automatic test_ras_depth();
    logic [63:0] links [9];
    logic [63:0] pc_exp;
    pc_exp = 64'hDEAD0;
    jump = 1'b1; call = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      links[k-1] = pc_exp + 64'h4;
      jump_target = 64'h1000 * 64'(k);
      tick();
      pc_exp = jump_target;
      tests_run++; if (index_out !== pc_exp) begin tests_failed++; $display("FAIL ras_push%0d index_out=%h exp=%h", k, index_out, pc_exp); end
    end
    tests_run++; if (ras_full !== 1'b1) begin tests_failed++; $display("FAIL ras_full full=%b exp=1", ras_full); end
    call = 1'b0; ret = 1'b1; jump_target = 64'hBAD00;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++; if (index_out !== links[8-i]) begin tests_failed++; $display("FAIL ras_pop%0d index_out=%h exp=%h", i, index_out, links[8-i]); end
    end
    tests_run++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin tests_failed++; $display("FAIL ras_drained empty/full=%b%b exp=10", ras_empty, ras_full); end
    tick();
    tests_run++; if (index_out !== 64'hBAD00) begin tests_failed++; $display("FAIL ras_underflow index_out=%h exp=%h", index_out, 64'hBAD00); end
    // reset in the middle of a call chain must discard pending entries
    ret = 1'b0; call = 1'b1; jump_target = 64'h500;
    tick();
    clear_ctl(); rst = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'h0 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ras_reset index_out=%h empty=%b exp=0 empty=1", index_out, ras_empty); end
    rst = 1'b0; jump = 1'b1; ret = 1'b1; jump_target = 64'h600;
    tick();
    tests_run++; if (index_out !== 64'h600) begin tests_failed++; $display("FAIL ras_stale index_out=%h exp=%h", index_out, 64'h600); end
    // call+ret together: return to top and replace it with the new link
    ret = 1'b0; call = 1'b1; jump_target = 64'h700;
    tick();
    ret = 1'b1; jump_target = 64'h900;
    tick();
    tests_run++; if (index_out !== 64'h604 || ras_empty !== 1'b0) begin tests_failed++; $display("FAIL ras_callret index_out=%h empty=%b exp=%h empty=0", index_out, ras_empty, 64'h604); end
    call = 1'b0;
    tick();
    tests_run++; if (index_out !== 64'h704 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL ras_replaced index_out=%h empty=%b exp=%h empty=1", index_out, ras_empty, 64'h704); end
    clear_ctl();
  endtask
`else
  task automatic test_ras();
    jump = 1'b1; call = 1'b1; jump_target = 64'h400;
    tick();
    tests_run++; if (index_out !== 64'h400 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin tests_failed++; $display("FAIL noras_call index_out=%h empty/full=%b%b exp=%h 10", index_out, ras_empty, ras_full, 64'h400); end
    call = 1'b0; ret = 1'b1; jump_target = 64'hDEAD0;
    tick();
    tests_run++; if (index_out !== 64'hDEAD0 || ras_empty !== 1'b1) begin tests_failed++; $display("FAIL noras_ret index_out=%h empty=%b exp=%h empty=1", index_out, ras_empty, 64'hDEAD0); end
    jump = 1'b0; ret = 1'b0; call = 1'b1;
    tick();
    tests_run++; if (index_out !== 64'hDEAD4) begin tests_failed++; $display("FAIL noras_call_nojump index_out=%h exp=%h", index_out, 64'hDEAD4); end
    clear_ctl();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch_stall();
    test_exception();
    test_wrap();
    test_jump();
    test_ras();
`ifdef PC_RAS_EN
    test_ras_depth();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
